// File: rtl/isa_io_master.sv
// isa_io_master: host-side ISA I/O cycle generator (setup, strobe with IOCHRDY wait states, hold)
module isa_io_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int MAX_WAIT   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [9:0] SA,
    output logic [7:0] SD_out,
    output logic       SD_oe,
    input  logic [7:0] SD_in,
    output logic       IOR,
    output logic       IOW,
    output logic       AEN,
    input  logic       IOCHRDY
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0] state;
    logic [7:0] cnt;
    logic       wr;
    logic       err;
    logic       strobe;

    // Bus pins decode straight from the registered state, so they change only on clock edges
    assign req_ready = state == S_IDLE;
    assign AEN       = req_ready;
    assign SD_oe     = wr && !req_ready;
    assign strobe    = state == S_STROBE || state == S_WAIT;
    assign IOR       = !(strobe && !wr);
    assign IOW       = !(strobe && wr);

    // Phase sequencer: one down-counter reloaded on every state entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr        <= 1'b0;
            err       <= 1'b0;
            SA        <= '0;
            SD_out    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    state  <= S_SETUP;
                    cnt    <= 8'(SETUP_CYC - 1);
                    wr     <= req_write;
                    SA     <= req_addr;
                    SD_out <= req_wdata;
                    err    <= 1'b0;
                end
                S_SETUP: if (cnt == 0) begin
                    state <= S_STROBE;
                    cnt   <= 8'(STROBE_CYC - 1);
                end else cnt <= cnt - 1'b1;
                S_STROBE: if (cnt != 0) cnt <= cnt - 1'b1;
                else if (IOCHRDY) begin
                    state <= S_HOLD;
                    cnt   <= 8'(HOLD_CYC - 1);
                    if (!wr) rsp_rdata <= SD_in;
                end else begin
                    state <= S_WAIT;
                    cnt   <= 8'(MAX_WAIT - 1);
                end
                S_WAIT: if (IOCHRDY) begin
                    state <= S_HOLD;
                    cnt   <= 8'(HOLD_CYC - 1);
                    if (!wr) rsp_rdata <= SD_in;
                end else if (cnt == 0) begin
                    state <= S_HOLD;
                    cnt   <= 8'(HOLD_CYC - 1);
                    err   <= 1'b1;
                end else cnt <= cnt - 1'b1;
                S_HOLD: if (cnt == 0) begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                end else cnt <= cnt - 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_isa_io_master.sv
// tb_isa_io_master: directed ISA cycles checked against a clock-index model of the bus timeline
module tb_isa_io_master;
    localparam int S  = 2;
    localparam int T  = 4;
    localparam int H  = 1;
    localparam int MX = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [9:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [9:0] SA;
    logic [7:0] SD_out;
    logic       SD_oe;
    logic [7:0] SD_in = '0;
    logic       IOR;
    logic       IOW;
    logic       AEN;
    logic       IOCHRDY = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    isa_io_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .MAX_WAIT(MX)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .SA(SA), .SD_out(SD_out), .SD_oe(SD_oe), .SD_in(SD_in),
        .IOR(IOR), .IOW(IOW), .AEN(AEN), .IOCHRDY(IOCHRDY)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position p within the transaction, wait length resolved from IOCHRDY samples
    logic       m_busy = 1'b0, m_res = 1'b0, m_err = 1'b0, m_wr = 1'b0, m_rsp = 1'b0, m_erro = 1'b0;
    int         m_p = 0, m_len = 0;
    logic [9:0] m_sa = '0;
    logic [7:0] m_sdout = '0, m_rdata = '0;

    always @(posedge clk) begin
        m_rsp  <= 1'b0;
        m_erro <= 1'b0;
        if (rst) begin
            m_busy <= 1'b0; m_rdata <= '0; m_sa <= '0; m_sdout <= '0; m_wr <= 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1; m_p <= 1; m_res <= 1'b0; m_err <= 1'b0;
                m_wr <= req_write; m_sa <= req_addr; m_sdout <= req_wdata;
            end
        end else if (m_res && m_p == m_len) begin
            m_busy <= 1'b0; m_rsp <= 1'b1; m_erro <= m_err;
        end else begin
            m_p <= m_p + 1;
            if (!m_res && m_p >= S + T) begin
                if (IOCHRDY) begin
                    m_res <= 1'b1; m_len <= m_p + H;
                    if (!m_wr) m_rdata <= SD_in;
                end else if (m_p - (S + T) == MX) begin
                    m_res <= 1'b1; m_len <= m_p + H; m_err <= 1'b1;
                end
            end
        end
    end

    logic m_low;
    assign m_low = m_busy && m_p > S && (!m_res || m_p <= m_len - H);

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(!m_busy));
            check("AEN", 32'(AEN), 32'(!m_busy));
            check("IOR", 32'(IOR), 32'(!(m_low && !m_wr)));
            check("IOW", 32'(IOW), 32'(!(m_low && m_wr)));
            check("SD_oe", 32'(SD_oe), 32'(m_busy && m_wr));
            check("SA", 32'(SA), 32'(m_sa));
            check("SD_out", 32'(SD_out), 32'(m_sdout));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            check("rsp_err", 32'(rsp_err), 32'(m_erro));
            check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        end
    end

    // One transaction; IOCHRDY is low in clocks lo_s..lo_s+lo_n-1 counted from acceptance
    task automatic txn(input string nm, input logic wr, input logic [9:0] a, input logic [7:0] d,
                       input logic [7:0] sd, input int lo_s, input int lo_n, input int exp_rsp,
                       input logic exp_err, input logic [7:0] exp_rd, input int exp_f, input int exp_l);
        int rk, lf, ll;
        logic e;
        logic [7:0] rd;
        rk = -1; lf = -1; ll = -1; e = 1'b0; rd = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; SD_in = sd; IOCHRDY = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (!IOR || !IOW) begin
                if (lf < 0) lf = k;
                ll = k;
            end
            if (rsp_valid) begin
                rk = k; e = rsp_err; rd = rsp_rdata;
                break;
            end
            IOCHRDY = !(k >= lo_s && k < lo_s + lo_n);
        end
        IOCHRDY = 1'b1;
        check({nm, " rsp clock"}, 32'(rk), 32'(exp_rsp));
        check({nm, " err"}, 32'(e), 32'(exp_err));
        check({nm, " rdata"}, 32'(rd), 32'(exp_rd));
        check({nm, " strobe first"}, 32'(lf), 32'(exp_f));
        check({nm, " strobe last"}, 32'(ll), 32'(exp_l));
    endtask

    initial begin
        int r1, r2, nrsp;
        logic sw;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset ready", 32'(req_ready), 32'h1);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rdata", 32'(rsp_rdata), 32'h0);
        check("reset IOR", 32'(IOR), 32'h1);
        check("reset IOW", 32'(IOW), 32'h1);
        check("reset AEN", 32'(AEN), 32'h1);
        check("reset SA", 32'(SA), 32'h0);
        check("reset SD_oe", 32'(SD_oe), 32'h0);
        chk_en = 1'b1;

        txn("read 2B0", 1'b0, 10'h2B0, 8'h00, 8'h5A, 0, 0, 8, 1'b0, 8'h5A, 3, 6);
        txn("write 2B1", 1'b1, 10'h2B1, 8'hC3, 8'h11, 0, 0, 8, 1'b0, 8'h5A, 3, 6);
        txn("read wait", 1'b0, 10'h2B2, 8'h00, 8'hA5, 6, 3, 11, 1'b0, 8'hA5, 3, 9);
        txn("read timeout", 1'b0, 10'h2B3, 8'h00, 8'h3C, 6, 100, 16, 1'b1, 8'hA5, 3, 14);

        // Back-to-back writes with req_valid held high
        r1 = -1; r2 = -1; sw = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h2B1; req_wdata = 8'h81;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sw) req_valid = 1'b0;
            if (rsp_valid && r1 < 0) begin
                r1 = k; req_addr = 10'h2B2; req_wdata = 8'h42; sw = 1'b1;
                check("b2b IOW between", 32'(IOW), 32'h1);
            end else if (rsp_valid) begin
                r2 = k;
                break;
            end
        end
        check("b2b first rsp", 32'(r1), 32'd8);
        check("b2b second rsp", 32'(r2), 32'd16);

        // Reset in clock 4 of a read
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h2B3; SD_in = 8'h77;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst IOR", 32'(IOR), 32'h1);
        check("rst AEN", 32'(AEN), 32'h1);
        check("rst SA", 32'(SA), 32'h0);
        check("rst ready", 32'(req_ready), 32'h1);
        nrsp = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        check("rst no rsp", 32'(nrsp), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
